// File: rtl/rv32i_types.sv
// Shared RV32 types for the execute stage: M-extension opcodes, the
// multiply/divide controller state encoding and related helpers.
package rv32i_types;

  typedef enum logic [2:0] {
    M_MUL    = 3'd0,
    M_MULH   = 3'd1,
    M_MULHSU = 3'd2,
    M_MULHU  = 3'd3,
    M_DIV    = 3'd4,
    M_DIVU   = 3'd5,
    M_REM    = 3'd6,
    M_REMU   = 3'd7
  } m_funct3_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

  localparam logic [31:0] DIV_OVF_DIVIDEND = 32'h8000_0000;

  function automatic logic op_is_div(input m_funct3_t f);
    return f inside {M_DIV, M_DIVU, M_REM, M_REMU};
  endfunction

  function automatic logic op_is_rem(input m_funct3_t f);
    return f inside {M_REM, M_REMU};
  endfunction

  // MUL only needs the low half, which is sign-agnostic, so it runs unsigned.
  function automatic logic op_a_signed(input m_funct3_t f);
    return f inside {M_MULH, M_MULHSU, M_DIV, M_REM};
  endfunction

  function automatic logic op_b_signed(input m_funct3_t f);
    return f inside {M_MULH, M_DIV, M_REM};
  endfunction

endpackage

// File: rtl/ex_muldiv_ctrl_core.sv
// Iterative unsigned datapath: left-shifting shift-add multiplier and
// restoring divider, one step per `step` pulse on operand magnitudes.
module muldiv_core #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                step,
  input  logic                is_div,
  input  logic [XLEN-1:0]     a_mag,
  input  logic [XLEN-1:0]     b_mag,
  input  logic [CNT_W-1:0]    pre_shift,
  output logic [2*XLEN-1:0]   step_prod,
  output logic [XLEN-1:0]     step_quo,
  output logic                mplr_last
);

  logic [2*XLEN-1:0] acc_reg, acc_next;
  logic [2*XLEN-1:0] mcand_reg, mcand_next;
  logic [XLEN-1:0]   q_reg, q_next;
  logic              is_div_reg;
  logic [XLEN:0]     r_shift;
  logic [XLEN+1:0]   diff;
  logic [XLEN:0]     r_sel;

  // acc holds the running product or partial remainder; q holds the
  // multiplier bits still to consume, or dividend bits shifting into quotient.
  always_comb begin
    acc_next   = acc_reg;
    mcand_next = mcand_reg;
    q_next     = q_reg;
    r_shift    = {acc_reg[XLEN-1:0], q_reg[XLEN-1]};
    diff       = {1'b0, r_shift} - {2'b00, mcand_reg[XLEN-1:0]};
    r_sel      = diff[XLEN+1] ? r_shift : diff[XLEN:0];
    if (is_div_reg) begin
      acc_next = {{(XLEN-1){1'b0}}, r_sel};
      q_next   = {q_reg[XLEN-2:0], ~diff[XLEN+1]};
    end else begin
      acc_next   = acc_reg + (q_reg[0] ? mcand_reg : '0);
      mcand_next = mcand_reg << 1;
      q_next     = {1'b0, q_reg[XLEN-1:1]};
    end
  end

  assign step_prod = acc_next;
  assign step_quo  = q_next;
  assign mplr_last = ~|q_reg[XLEN-1:1];

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg    <= '0;
      mcand_reg  <= '0;
      q_reg      <= '0;
      is_div_reg <= 1'b0;
    end else if (load) begin
      acc_reg    <= '0;
      mcand_reg  <= {{XLEN{1'b0}}, b_mag};
      q_reg      <= is_div ? (a_mag << pre_shift) : a_mag;
      is_div_reg <= is_div;
    end else if (step) begin
      acc_reg   <= acc_next;
      mcand_reg <= mcand_next;
      q_reg     <= q_next;
    end
  end

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// RV32M sequencing controller for EX: capture, iterate, sign fixup, stall.
// Optional MULDIV_EARLY_OUT_EN shortens multiply/divide iteration counts.
module ex_muldiv_ctrl
  import rv32i_types::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  input  logic            pipe_stall_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY_OUT = 1'b1;
`else
  localparam bit EARLY_OUT = 1'b0;
`endif

  muldiv_state_t     state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [XLEN-1:0]   result_reg, result_next;
  m_funct3_t         op_reg, op_next;
  logic              a_neg_reg, a_neg_next;
  logic              b_neg_reg, b_neg_next;

  m_funct3_t         op_in;
  logic              cap_div, cap_a_neg, cap_b_neg;
  logic [XLEN-1:0]   cap_a_mag, cap_b_mag;
  logic [CNT_W-1:0]  div_lz, pre_shift;
  logic              lz_found;
  logic              core_load, core_step, last_step;
  logic [2*XLEN-1:0] step_prod, prod_fix;
  logic [XLEN-1:0]   step_quo, quo_fix, rem_fix, fix_result;
  logic              mplr_last;

  assign op_in     = m_funct3_t'(funct3_i);
  assign cap_div   = op_is_div(op_in);
  assign cap_a_neg = op_a_signed(op_in) & rs1_i[XLEN-1];
  assign cap_b_neg = op_b_signed(op_in) & rs2_i[XLEN-1];
  assign cap_a_mag = cap_a_neg ? -rs1_i : rs1_i;
  assign cap_b_mag = cap_b_neg ? -rs2_i : rs2_i;

  // Leading zeros of the dividend magnitude, clamped so at least one step runs.
  always_comb begin
    div_lz   = '0;
    lz_found = 1'b0;
    for (int i = XLEN - 1; i >= 0; i--) begin
      if (!lz_found) begin
        if (cap_a_mag[i]) lz_found = 1'b1;
        else              div_lz   = div_lz + CNT_W'(1);
      end
    end
    if (div_lz > CNT_W'(XLEN - 1)) div_lz = CNT_W'(XLEN - 1);
  end

  assign pre_shift = (EARLY_OUT && cap_div) ? div_lz : '0;

  muldiv_core #(.XLEN(XLEN), .CNT_W(CNT_W)) u_core (
    .clk       (clk),
    .rst       (rst),
    .load      (core_load),
    .step      (core_step),
    .is_div    (cap_div),
    .a_mag     (cap_a_mag),
    .b_mag     (cap_b_mag),
    .pre_shift (pre_shift),
    .step_prod (step_prod),
    .step_quo  (step_quo),
    .mplr_last (mplr_last)
  );

  assign prod_fix = (a_neg_reg ^ b_neg_reg) ? -step_prod : step_prod;
  assign quo_fix  = (a_neg_reg ^ b_neg_reg) ? -step_quo : step_quo;
  assign rem_fix  = a_neg_reg ? -step_prod[XLEN-1:0] : step_prod[XLEN-1:0];

  always_comb begin
    case (op_reg)
      M_MUL:                    fix_result = prod_fix[XLEN-1:0];
      M_MULH, M_MULHSU, M_MULHU: fix_result = prod_fix[2*XLEN-1:XLEN];
      M_DIV, M_DIVU:            fix_result = quo_fix;
      default:                  fix_result = rem_fix;
    endcase
  end

  assign last_step = (cnt_reg == CNT_W'(XLEN - 1)) ||
                     (EARLY_OUT && !op_is_div(op_reg) && mplr_last);

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    result_next = result_reg;
    op_next     = op_reg;
    a_neg_next  = a_neg_reg;
    b_neg_next  = b_neg_reg;
    core_load   = 1'b0;
    core_step   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (valid_i) begin
          op_next    = op_in;
          a_neg_next = cap_a_neg;
          b_neg_next = cap_b_neg;
          core_load  = 1'b1;
          if (cap_div && (rs2_i == '0)) begin
            result_next = op_is_rem(op_in) ? rs1_i : '1;
            state_next  = DONE;
          end else if (cap_div && op_b_signed(op_in) &&
                       (rs1_i == DIV_OVF_DIVIDEND) && (rs2_i == '1)) begin
            result_next = op_is_rem(op_in) ? '0 : DIV_OVF_DIVIDEND;
            state_next  = DONE;
          end else begin
            cnt_next   = pre_shift;
            state_next = BUSY;
          end
        end
      end
      BUSY: begin
        core_step = 1'b1;
        if (last_step) begin
          result_next = fix_result;
          cnt_next    = '0;
          state_next  = DONE;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      DONE: begin
        if (!pipe_stall_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // A redirect discards whatever was in flight, including a fresh capture.
    if (flush_i) begin
      state_next  = IDLE;
      cnt_next    = '0;
      result_next = result_reg;
      core_load   = 1'b0;
      core_step   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      result_reg <= '0;
      op_reg     <= M_MUL;
      a_neg_reg  <= 1'b0;
      b_neg_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      result_reg <= result_next;
      op_reg     <= op_next;
      a_neg_reg  <= a_neg_next;
      b_neg_reg  <= b_neg_next;
    end
  end

  assign stall_o  = ~rst & valid_i & ~flush_i & (state_reg != DONE);
  assign done_o   = (state_reg == DONE);
  assign result_o = result_reg;

  // The ID/EX register must hold the instruction while the unit iterates.
  valid_held_while_busy: assert property (
    @(posedge clk) disable iff (rst) ((state_reg == BUSY) && !flush_i) |-> valid_i);

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Directed bench for ex_muldiv_ctrl: latency, results, special cases,
// flush, downstream stall hold and mid-operation reset.
module tb_ex_muldiv_ctrl;

  logic        clk;
  logic        rst;
  logic        valid_i;
  logic [2:0]  funct3_i;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic        flush_i;
  logic        pipe_stall_i;
  logic        stall_o;
  logic        done_o;
  logic [31:0] result_o;

  int total = 0;
  int bad   = 0;

  ex_muldiv_ctrl #(.XLEN(32), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid_i),
    .funct3_i     (funct3_i),
    .rs1_i        (rs1_i),
    .rs2_i        (rs2_i),
    .flush_i      (flush_i),
    .pipe_stall_i (pipe_stall_i),
    .stall_o      (stall_o),
    .done_o       (done_o),
    .result_o     (result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Issue one op in the current (IDLE) cycle, measure cycles to done_o,
  // optionally hold DONE with pipe_stall_i, then let the pipeline advance.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat, input int hold,
                        input string tag);
    int cyc;
    int stalls;
    valid_i      = 1'b1;
    funct3_i     = f3;
    rs1_i        = a;
    rs2_i        = b;
    pipe_stall_i = 1'b0;
    #1;
    cyc    = 0;
    stalls = 0;
    while (!done_o && cyc < 40) begin
      if (stall_o) stalls++;
      tick();
      cyc++;
    end
    check({tag, "_latency"}, cyc, exp_lat);
    check({tag, "_stall_cycles"}, stalls, exp_lat);
    check({tag, "_result"}, result_o, exp);
    if (hold > 0) begin
      pipe_stall_i = 1'b1;
      for (int i = 0; i < hold; i++) begin
        tick();
        check({tag, "_hold_done"}, done_o, 1);
        check({tag, "_hold_result"}, result_o, exp);
        check({tag, "_hold_stall"}, stall_o, 0);
      end
      pipe_stall_i = 1'b0;
    end
    tick();
    check({tag, "_idle_done"}, done_o, 0);
    valid_i = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    valid_i      = 1'b0;
    funct3_i     = 3'd0;
    rs1_i        = '0;
    rs2_i        = '0;
    flush_i      = 1'b0;
    pipe_stall_i = 1'b0;

    tick();
    tick();
    check("rst_stall", stall_o, 0);
    check("rst_done", done_o, 0);
    check("rst_result", result_o, 0);
    rst = 1'b0;
    tick();
    check("post_rst_stall", stall_o, 0);
    check("post_rst_done", done_o, 0);
    check("post_rst_result", result_o, 0);

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 0, "mul_7x-3");
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 0, "mulhu");
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33, 0, "mulhsu");
    run_op(3'd1, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 33, 0, "mulh_-2x3");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0, "div_-7/2");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0, "rem_-7/2");
    run_op(3'd5, 32'd100, 32'd7, 32'd14, 33, 0, "divu_100/7");
    run_op(3'd7, 32'd100, 32'd7, 32'd2, 33, 0, "remu_100/7_b2b");
    run_op(3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0, "div_5/0");
    run_op(3'd6, 32'd5, 32'd0, 32'd5, 1, 0, "rem_5/0");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, "div_ovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0, "rem_ovf");

    // Flush in BUSY cycle 10, then an immediate new op.
    valid_i  = 1'b1;
    funct3_i = 3'd5;
    rs1_i    = 32'd1000;
    rs2_i    = 32'd7;
    #1;
    for (int i = 0; i < 10; i++) tick();
    check("busy10_stall", stall_o, 1);
    flush_i = 1'b1;
    #1;
    check("flush_stall", stall_o, 0);
    check("flush_done", done_o, 0);
    tick();
    flush_i = 1'b0;
    check("after_flush_done", done_o, 0);
    run_op(3'd5, 32'd9, 32'd3, 32'd3, 33, 0, "divu_9/3_after_flush");

    run_op(3'd0, 32'd6, 32'd7, 32'd42, 33, 4, "mul_hold");

    // Reset in the middle of BUSY.
    valid_i  = 1'b1;
    funct3_i = 3'd4;
    rs1_i    = 32'd100;
    rs2_i    = 32'd7;
    #1;
    for (int i = 0; i < 5; i++) tick();
    check("busy5_done", done_o, 0);
    rst     = 1'b1;
    valid_i = 1'b0;
    tick();
    check("midrst_stall", stall_o, 0);
    check("midrst_done", done_o, 0);
    check("midrst_result", result_o, 0);
    rst = 1'b0;
    tick();
    check("after_midrst_done", done_o, 0);
    check("after_midrst_stall", stall_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_ctrl.md
Name: ex_muldiv_ctrl

Overview:
- Sequencing controller for RV32M ops in the EX stage. Captures operands from ID/EX, runs an iterative shift-add multiplier / restoring divider, stalls the pipeline until the result is ready, then holds the result until the pipeline advances.
- Sits beside the ALU/CMP in execute. Its result is muxed onto alu_out for M-type instructions, and its stall is ORed into the global pipeline stall.

Parameters:
- XLEN, 32, operand/result width
- CNT_W, 6, iteration counter width (must hold XLEN)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- valid_i  in  1  M-type instruction present in EX; held stable while stall_o=1
- funct3_i  in  3  M op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- rs1_i  in  XLEN  operand a (post-forwarding)
- rs2_i  in  XLEN  operand b (post-forwarding)
- flush_i  in  1  EX flush (taken branch/jalr redirect)
- pipe_stall_i  in  1  downstream stall (memory); EX/MEM will not latch this cycle
- stall_o  out  1  request pipeline freeze
- done_o  out  1  result_o valid
- result_o  out  XLEN  final result

Behaviour:
- States: IDLE, BUSY, DONE.
- Reset: state=IDLE, counter=0, result register=0. stall_o=0, done_o=0, result_o=0 during and after reset until an op starts.
- IDLE, valid_i=1, flush_i=0:
  - Latch funct3, operand magnitudes and sign flags. Clear the accumulator.
  - Next state is BUSY, or DONE directly for a special case.
- Special cases, resolved at capture, 1 cycle to DONE:
  - div/rem by zero: quotient=all ones, remainder=rs1.
  - Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF, DIV/REM): quotient=0x80000000, remainder=0.
- BUSY: one bit per cycle for XLEN cycles. Counter counts 0..XLEN-1; at XLEN-1, go to DONE.
- Result fixup, registered on entry to DONE:
  - Negate the product if operand signs differ, per op signedness. MULHSU treats rs2 as unsigned.
  - Quotient sign = sign(a) XOR sign(b). Remainder sign = sign(a).
  - MUL returns product[31:0]. MULH/MULHSU/MULHU return product[63:32].
- DONE:
  - done_o=1, result_o stable.
  - pipe_stall_i=0: pipeline advances this cycle; next state is IDLE.
  - pipe_stall_i=1: stay in DONE.
- stall_o = valid_i & ~flush_i & (state != DONE). Combinational. Also 0 in the IDLE cycle if valid_i=0.
- Latency, fixed path: valid_i rises in cycle 0 (IDLE capture), BUSY in cycles 1..32, DONE in cycle 33. stall_o is high in cycles 0..32.
- Latency, special case: DONE in cycle 1.
- Back-to-back ops: the cycle after DONE→IDLE, valid_i belongs to the next instruction and a new capture starts. There is no bubble beyond the IDLE capture cycle.
- Flush in any state: next state is IDLE, the op is discarded, done_o does not assert, and stall_o=0 in the flush cycle. Flush outranks a new capture in IDLE.
- rst in any state overrides flush and everything else.
- valid_i dropping while BUSY without flush is illegal (assertion). The controller continues, then waits in DONE.

Optional Feature:
- Macro MULDIV_EARLY_OUT_EN.
- Defined: multiply leaves BUSY as soon as the remaining multiplier bits are all zero (minimum 1 BUSY cycle). Divide skips leading-zero dividend bits at capture, pre-shifting and loading the counter accordingly. Results are unchanged.
- Undefined: fixed XLEN BUSY cycles for every non-special op.

Decomposition:
- rv32i_types gains:
  - m_funct3_t enum (mul, mulh, mulhsu, mulhu, div, divu, rem, remu)
  - muldiv_state_t enum (IDLE, BUSY, DONE)
  - constant DIV_OVF_DIVIDEND = 32'h80000000
- Sub-module muldiv_core: iterative datapath only (64-bit accumulator/remainder, shift, add/sub, one step per `step` pulse).
- ex_muldiv_ctrl holds the FSM, counter, sign fixup, special-case detection and stall logic.

Test Plan:
- MUL 7*(-3): rs1=7, rs2=0xFFFFFFFD → stall_o high 33 cycles, done_o in cycle 33, result_o=0xFFFFFFEB.
- MULHU 0xFFFFFFFF*0xFFFFFFFF → 0xFFFFFFFE. Then MULHSU rs1=0xFFFFFFFF, rs2=2 → 0xFFFFFFFF.
- DIV -7/2 → 0xFFFFFFFD. REM -7/2 → 0xFFFFFFFF. DIVU 100/7 → 14, then back-to-back REMU 100/7 → 2 with exactly one IDLE capture cycle between.
- DIV 5/0 → 0xFFFFFFFF in cycle 1; REM 5/0 → 5. DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same → 0.
- Flush at BUSY cycle 10 → stall_o=0 that cycle, IDLE next, no done_o. A new DIVU 9/3 issued immediately after → 3.
- pipe_stall_i=1 for 4 cycles during DONE → result_o held and done_o=1 throughout. rst mid-BUSY → all outputs 0 next cycle, state IDLE.
